// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle signed/unsigned multiply and divide unit that owns
//            the HI/LO result registers. Operands are reduced to magnitudes
//            at launch. One shift-add (multiply) or restoring-subtract
//            (divide) step runs per cycle. The sign is restored in a final
//            FIX cycle.
// Ports    : clk, reset (async, active-high)
//            start, op[1:0], a, b    launch handshake and operands
//            flush                   abort the operation in flight
//            hi_wr, lo_wr, wr_data   direct HI/LO writes while idle
//            busy, done, div_by_zero status; div_by_zero is valid with done
//            hi, lo                  HI/LO registers
// Options  : MULDIV_EARLY_OUT_EN - multiply leaves CALC once the remaining
//            multiplier bits are zero, and divide-by-zero leaves CALC after
//            one step. Results are identical with and without it.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              c_CW       = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    logic [1:0]       r_state, w_state_next;
    logic [c_CW-1:0]  r_cnt, w_cnt_next;
    logic             r_is_div, r_neg_q, r_neg_r, r_dbz;
    logic [WIDTH-1:0] r_a;
    // r_acc : product high half (multiply) or partial remainder (divide)
    // r_mq  : multiplier shifting out / product low half shifting in, or
    //         dividend shifting out / quotient shifting in
    // r_opnd: |multiplicand| or |divisor|
    logic [WIDTH-1:0] r_acc, r_mq, r_opnd;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_done, r_dbz_out;

    // ---------------- launch: operand magnitudes and sign flags ------------
    logic             w_accept, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign w_a_neg  = ~op[0] & a[WIDTH-1];
    assign w_b_neg  = ~op[0] & b[WIDTH-1];
    // The most-negative value maps to 2**(WIDTH-1), which still fits as unsigned.
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    // A flush in the same cycle wins over start.
    assign w_accept = (r_state == c_ST_IDLE) & start & ~flush;

    // ---------------- one iteration step ----------------------------------
    logic [WIDTH:0]   w_mul_sum, w_div_shift;
    logic [WIDTH-1:0] w_div_sub, w_acc_next, w_mq_next;
    logic             w_div_ge, w_calc_last;

    assign w_mul_sum   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opnd} : '0);
    assign w_div_shift = {r_acc, r_mq[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    // The difference is below the divisor when taken, so WIDTH bits suffice.
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;

    assign w_acc_next  = r_is_div ? (w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0])
                                  : w_mul_sum[WIDTH:1];
    assign w_mq_next   = r_is_div ? {r_mq[WIDTH-2:0], w_div_ge}
                                  : {w_mul_sum[0], r_mq[WIDTH-1:1]};
    assign w_cnt_next  = r_cnt - c_CNT_ONE;

    // ---------------- result formation ------------------------------------
    logic [2*WIDTH-1:0] w_prod_mag, w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_hi_res, w_lo_res;

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] w_rem_mask;

    // The low w_cnt_next bits of r_mq still hold unconsumed multiplier bits.
    assign w_rem_mask  = ~({WIDTH{1'b1}} << w_cnt_next);
    assign w_calc_last = (w_cnt_next == '0) |
                         (r_is_div ? r_dbz : ((w_mq_next & w_rem_mask) == '0));
    // After an early exit the product still sits r_cnt places to the left.
    assign w_prod_mag  = {r_acc, r_mq} >> r_cnt;
`else
    assign w_calc_last = (w_cnt_next == '0);
    assign w_prod_mag  = {r_acc, r_mq};
`endif

    assign w_prod   = r_neg_q ? -w_prod_mag : w_prod_mag;
    assign w_quo    = r_neg_q ? -r_mq : r_mq;
    assign w_rem    = r_neg_r ? -r_acc : r_acc;
    assign w_hi_res = r_is_div ? (r_dbz ? r_a : w_rem) : w_prod[2*WIDTH-1:WIDTH];
    assign w_lo_res = r_is_div ? (r_dbz ? '1 : w_quo) : w_prod[WIDTH-1:0];

    // ---------------- control FSM -----------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_next = c_ST_CALC;
            c_ST_CALC: begin
                if (flush)            w_state_next = c_ST_IDLE;
                else if (w_calc_last) w_state_next = c_ST_FIX;
            end
            c_ST_FIX:  w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // ---------------- datapath and result registers -----------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
            r_a       <= '0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dbz    <= op[1] & (b == '0);
                        r_a      <= a;
                        r_acc    <= '0;
                        r_mq     <= op[1] ? w_a_mag : w_b_mag;
                        r_opnd   <= op[1] ? w_b_mag : w_a_mag;
                        r_cnt    <= c_CNT_LOAD;
                    end else begin
                        if (hi_wr) r_hi <= wr_data;
                        if (lo_wr) r_lo <= wr_data;
                    end
                end
                c_ST_CALC: begin
                    if (!flush) begin
                        r_acc <= w_acc_next;
                        r_mq  <= w_mq_next;
                        r_cnt <= w_cnt_next;
                    end
                end
                c_ST_FIX: begin
                    if (!flush) begin
                        r_hi      <= w_hi_res;
                        r_lo      <= w_lo_res;
                        r_done    <= 1'b1;
                        r_dbz_out <= r_dbz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != c_ST_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz_out;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire
